// File: rtl/job_sequencer_pkg.sv
// Shared types for the job sequencer: run-controller states and error codes.
package job_seq_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD_IMEM   = 3'd1,
        LOAD_DMEM   = 3'd2,
        EXECUTE     = 3'd3,
        UNLOAD_DMEM = 3'd4,
        DONE        = 3'd5,
        ERROR       = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_COMM  = 2'd1,
        ERR_EXEC  = 2'd2,
        ERR_ABORT = 2'd3
    } err_t;

    // States in which the sequencer waits on an external agent and the watchdog runs.
    function automatic logic is_busy(input state_t s);
        return (s == LOAD_IMEM) || (s == LOAD_DMEM) || (s == EXECUTE) || (s == UNLOAD_DMEM);
    endfunction

endpackage

// File: rtl/job_sequencer_phase_watchdog.sv
// Per-phase cycle counter; expires when a phase has lasted TIMEOUT cycles (0 disables it).
module phase_watchdog #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Restart on every phase entry, otherwise count enabled cycles without wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (TIMEOUT != 0) && enable && (count_q == LIMIT);

endmodule

// File: rtl/job_sequencer.sv
// Run controller: load IMEM -> load DMEM -> execute -> unload DMEM, with reruns,
// IMEM reuse, watchdog, abort, error state, cycle/run counters and memory port muxes.
module job_sequencer
    import job_seq_pkg::*;
#(
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int DATA_MEM_WIDTH      = 60,
    parameter int INS_MEM_ADDR_WIDTH  = 8,
    parameter int INS_WIDTH           = 8,
    parameter int CYCLE_CNT_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES      = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           keep_imem,
    input  logic                           imem_rx_done,
    input  logic                           dmem_rx_done,
    input  logic                           proc_done,
    input  logic                           dmem_tx_done,
    output logic                           imem_rx_en,
    output logic                           dmem_rx_en,
    output logic                           proc_start,
    output logic                           dmem_tx_start,
    input  logic                           uart_imem_wr_en,
    input  logic [INS_MEM_ADDR_WIDTH-1:0]  uart_imem_addr,
    input  logic [INS_WIDTH-1:0]           uart_imem_data,
    input  logic [INS_MEM_ADDR_WIDTH-1:0]  proc_imem_addr,
    output logic                           imem_wr_en,
    output logic [INS_MEM_ADDR_WIDTH-1:0]  imem_addr,
    output logic [INS_WIDTH-1:0]           imem_data,
    input  logic                           uart_dmem_wr_en,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0] uart_dmem_addr,
    input  logic [DATA_MEM_WIDTH-1:0]      uart_dmem_data,
    input  logic                           proc_dmem_wr_en,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0] proc_dmem_addr,
    input  logic [DATA_MEM_WIDTH-1:0]      proc_dmem_data,
    output logic                           dmem_wr_en,
    output logic [DATA_MEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_MEM_WIDTH-1:0]      dmem_data,
    output logic [2:0]                     state,
    output logic [CYCLE_CNT_WIDTH-1:0]     exec_cycles,
    output logic [15:0]                    run_count,
    output logic                           error,
    output logic [1:0]                     err_code
);

    state_t                     state_q, state_d;
    err_t                       err_code_q, err_code_d;
    logic                       imem_valid_q, imem_valid_d;
    logic [CYCLE_CNT_WIDTH-1:0] exec_cycles_q, exec_cycles_d;
    logic [15:0]                run_count_q, run_count_d;
    logic                       imem_rx_en_q, imem_rx_en_d;
    logic                       dmem_rx_en_q, dmem_rx_en_d;
    logic                       proc_start_q, proc_start_d;
    logic                       dmem_tx_start_q, dmem_tx_start_d;
    logic                       error_q, error_d;
    logic                       timeout;

    phase_watchdog #(
        .WIDTH   (CYCLE_CNT_WIDTH),
        .TIMEOUT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_d != state_q),
        .enable (is_busy(state_q)),
        .expire (timeout)
    );

    // Next-state, counters and registered strobes; abort beats timeout beats phase-done.
    always_comb begin
        state_d       = state_q;
        err_code_d    = err_code_q;
        imem_valid_d  = imem_valid_q;
        exec_cycles_d = exec_cycles_q;
        run_count_d   = run_count_q;
        if (abort && (state_q != IDLE) && (state_q != ERROR)) begin
            state_d    = ERROR;
            err_code_d = ERR_ABORT;
        end else if (timeout) begin
            state_d    = ERROR;
            err_code_d = (state_q == EXECUTE) ? ERR_EXEC : ERR_COMM;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = (keep_imem && imem_valid_q) ? LOAD_DMEM : LOAD_IMEM;
                    end
                end
                LOAD_IMEM: begin
                    if (imem_rx_done) begin
                        state_d      = LOAD_DMEM;
                        imem_valid_d = 1'b1;
                    end
                end
                LOAD_DMEM: begin
                    if (dmem_rx_done) begin
                        state_d = EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (proc_done) begin
                        state_d = UNLOAD_DMEM;
                    end
                end
                UNLOAD_DMEM: begin
                    if (dmem_tx_done) begin
                        state_d     = DONE;
                        run_count_d = run_count_q + 16'd1;
                    end
                end
                ERROR: begin
                    if (start) begin
                        state_d    = IDLE;
                        err_code_d = ERR_NONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d == ERROR) begin
            imem_valid_d = 1'b0;
        end
        if (state_d == EXECUTE) begin
            if (state_q != EXECUTE) begin
                exec_cycles_d = '0;
            end else if (exec_cycles_q != '1) begin
                exec_cycles_d = exec_cycles_q + CYCLE_CNT_WIDTH'(1);
            end
        end
        imem_rx_en_d    = (state_d == LOAD_IMEM);
        dmem_rx_en_d    = (state_d == LOAD_DMEM);
        proc_start_d    = (state_d == EXECUTE) && (state_q != EXECUTE);
        dmem_tx_start_d = (state_d == UNLOAD_DMEM) && (state_q != UNLOAD_DMEM);
        error_d         = (state_d == ERROR);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            err_code_q      <= ERR_NONE;
            imem_valid_q    <= 1'b0;
            exec_cycles_q   <= '0;
            run_count_q     <= '0;
            imem_rx_en_q    <= 1'b0;
            dmem_rx_en_q    <= 1'b0;
            proc_start_q    <= 1'b0;
            dmem_tx_start_q <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            err_code_q      <= err_code_d;
            imem_valid_q    <= imem_valid_d;
            exec_cycles_q   <= exec_cycles_d;
            run_count_q     <= run_count_d;
            imem_rx_en_q    <= imem_rx_en_d;
            dmem_rx_en_q    <= dmem_rx_en_d;
            proc_start_q    <= proc_start_d;
            dmem_tx_start_q <= dmem_tx_start_d;
            error_q         <= error_d;
        end
    end

    // Memory port muxes: each memory belongs to whichever agent owns the current phase.
    always_comb begin
        imem_wr_en = 1'b0;
        imem_addr  = '0;
        imem_data  = '0;
        dmem_wr_en = 1'b0;
        dmem_addr  = '0;
        dmem_data  = '0;
        case (state_q)
            LOAD_IMEM: begin
                imem_wr_en = uart_imem_wr_en;
                imem_addr  = uart_imem_addr;
                imem_data  = uart_imem_data;
            end
            LOAD_DMEM, UNLOAD_DMEM: begin
                dmem_wr_en = uart_dmem_wr_en;
                dmem_addr  = uart_dmem_addr;
                dmem_data  = uart_dmem_data;
            end
            EXECUTE: begin
                imem_addr  = proc_imem_addr;
                dmem_wr_en = proc_dmem_wr_en;
                dmem_addr  = proc_dmem_addr;
                dmem_data  = proc_dmem_data;
            end
            default: ;
        endcase
    end

    assign state         = state_q;
    assign err_code      = err_code_q;
    assign exec_cycles   = exec_cycles_q;
    assign run_count     = run_count_q;
    assign imem_rx_en    = imem_rx_en_q;
    assign dmem_rx_en    = dmem_rx_en_q;
    assign proc_start    = proc_start_q;
    assign dmem_tx_start = dmem_tx_start_q;
    assign error         = error_q;

endmodule

// File: tb/tb_job_sequencer.sv
// Self-checking bench for job_sequencer: directed scenarios plus randomized traffic,
// all compared every cycle against a phase-level behavioural model.
module tb_job_sequencer;

    localparam int DA  = 12;
    localparam int DW  = 60;
    localparam int IA  = 8;
    localparam int IW  = 8;
    localparam int CCW = 32;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          keep_imem = 1'b0;
    logic          imem_rx_done = 1'b0;
    logic          dmem_rx_done = 1'b0;
    logic          proc_done = 1'b0;
    logic          dmem_tx_done = 1'b0;
    logic          uart_imem_wr_en = 1'b0;
    logic [IA-1:0] uart_imem_addr = '0;
    logic [IW-1:0] uart_imem_data = '0;
    logic [IA-1:0] proc_imem_addr = '0;
    logic          uart_dmem_wr_en = 1'b0;
    logic [DA-1:0] uart_dmem_addr = '0;
    logic [DW-1:0] uart_dmem_data = '0;
    logic          proc_dmem_wr_en = 1'b0;
    logic [DA-1:0] proc_dmem_addr = '0;
    logic [DW-1:0] proc_dmem_data = '0;

    logic           imem_rx_en, dmem_rx_en, proc_start, dmem_tx_start;
    logic           imem_wr_en, dmem_wr_en, error;
    logic [IA-1:0]  imem_addr;
    logic [IW-1:0]  imem_data;
    logic [DA-1:0]  dmem_addr;
    logic [DW-1:0]  dmem_data;
    logic [2:0]     state;
    logic [CCW-1:0] exec_cycles;
    logic [15:0]    run_count;
    logic [1:0]     err_code;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    int done_odds = 12;

    int cnt_proc_start = 0;
    int cnt_tx_start = 0;
    int cnt_imem_rx_en = 0;

    // Behavioural model: phase and how long we have been in it.
    int m_state = 0;
    int m_phase = 0;
    int m_err = 0;
    int m_runs = 0;
    int m_last_exec = 0;
    bit m_imem_valid = 1'b0;

    job_sequencer #(
        .DATA_MEM_ADDR_WIDTH (DA),
        .DATA_MEM_WIDTH      (DW),
        .INS_MEM_ADDR_WIDTH  (IA),
        .INS_WIDTH           (IW),
        .CYCLE_CNT_WIDTH     (CCW),
        .TIMEOUT_CYCLES      (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .keep_imem       (keep_imem),
        .imem_rx_done    (imem_rx_done),
        .dmem_rx_done    (dmem_rx_done),
        .proc_done       (proc_done),
        .dmem_tx_done    (dmem_tx_done),
        .imem_rx_en      (imem_rx_en),
        .dmem_rx_en      (dmem_rx_en),
        .proc_start      (proc_start),
        .dmem_tx_start   (dmem_tx_start),
        .uart_imem_wr_en (uart_imem_wr_en),
        .uart_imem_addr  (uart_imem_addr),
        .uart_imem_data  (uart_imem_data),
        .proc_imem_addr  (proc_imem_addr),
        .imem_wr_en      (imem_wr_en),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .uart_dmem_wr_en (uart_dmem_wr_en),
        .uart_dmem_addr  (uart_dmem_addr),
        .uart_dmem_data  (uart_dmem_data),
        .proc_dmem_wr_en (proc_dmem_wr_en),
        .proc_dmem_addr  (proc_dmem_addr),
        .proc_dmem_data  (proc_dmem_data),
        .dmem_wr_en      (dmem_wr_en),
        .dmem_addr       (dmem_addr),
        .dmem_data       (dmem_data),
        .state           (state),
        .exec_cycles     (exec_cycles),
        .run_count       (run_count),
        .error           (error),
        .err_code        (err_code)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Advance the model by one clock using the inputs as sampled on that edge.
    task automatic model_step();
        int  nxt;
        bit  busy;
        if (rst) begin
            m_state = 0; m_phase = 0; m_err = 0; m_runs = 0; m_last_exec = 0; m_imem_valid = 1'b0;
            return;
        end
        busy = (m_state >= 1) && (m_state <= 4);
        nxt = m_state;
        if (abort && m_state != 0 && m_state != 6) begin
            nxt = 6; m_err = 3;
        end else if (busy && m_phase == TMO - 1) begin
            nxt = 6; m_err = (m_state == 3) ? 2 : 1;
        end else begin
            case (m_state)
                0, 5: if (start) nxt = (keep_imem && m_imem_valid) ? 2 : 1;
                1: if (imem_rx_done) begin nxt = 2; m_imem_valid = 1'b1; end
                2: if (dmem_rx_done) nxt = 3;
                3: if (proc_done) nxt = 4;
                4: if (dmem_tx_done) begin nxt = 5; m_runs = (m_runs + 1) % 65536; end
                6: if (start) begin nxt = 0; m_err = 0; end
                default: nxt = 0;
            endcase
        end
        if (nxt == 6) m_imem_valid = 1'b0;
        if (m_state == 3 && nxt != 3) m_last_exec = m_phase;
        m_phase = (nxt != m_state) ? 0 : m_phase + 1;
        m_state = nxt;
    endtask

    // Compare every output against what the model says the current phase implies.
    task automatic check_output();
        int            exp_exec;
        logic          e_iwe, e_dwe;
        logic [IA-1:0] e_ia;
        logic [IW-1:0] e_id;
        logic [DA-1:0] e_da;
        logic [DW-1:0] e_dd;
        exp_exec = (m_state == 3) ? m_phase : m_last_exec;
        e_iwe = 1'b0; e_ia = '0; e_id = '0; e_dwe = 1'b0; e_da = '0; e_dd = '0;
        if (m_state == 1) begin
            e_iwe = uart_imem_wr_en; e_ia = uart_imem_addr; e_id = uart_imem_data;
        end
        if (m_state == 3) begin
            e_ia = proc_imem_addr;
            e_dwe = proc_dmem_wr_en; e_da = proc_dmem_addr; e_dd = proc_dmem_data;
        end
        if (m_state == 2 || m_state == 4) begin
            e_dwe = uart_dmem_wr_en; e_da = uart_dmem_addr; e_dd = uart_dmem_data;
        end
        check_val("state", 64'(state), 64'(m_state));
        check_val("imem_rx_en", 64'(imem_rx_en), 64'(m_state == 1));
        check_val("dmem_rx_en", 64'(dmem_rx_en), 64'(m_state == 2));
        check_val("proc_start", 64'(proc_start), 64'(m_state == 3 && m_phase == 0));
        check_val("dmem_tx_start", 64'(dmem_tx_start), 64'(m_state == 4 && m_phase == 0));
        check_val("error", 64'(error), 64'(m_state == 6));
        check_val("err_code", 64'(err_code), 64'(m_err));
        check_val("run_count", 64'(run_count), 64'(m_runs));
        check_val("exec_cycles", 64'(exec_cycles), 64'(exp_exec));
        check_val("imem_wr_en", 64'(imem_wr_en), 64'(e_iwe));
        check_val("imem_addr", 64'(imem_addr), 64'(e_ia));
        check_val("imem_data", 64'(imem_data), 64'(e_id));
        check_val("dmem_wr_en", 64'(dmem_wr_en), 64'(e_dwe));
        check_val("dmem_addr", 64'(dmem_addr), 64'(e_da));
        check_val("dmem_data", 64'(dmem_data), 64'(e_dd));
        if (proc_start) cnt_proc_start++;
        if (dmem_tx_start) cnt_tx_start++;
        if (imem_rx_en) cnt_imem_rx_en++;
    endtask

    task automatic apply_stimulus();
        rst             = ($urandom_range(0, 999) == 0);
        start           = ($urandom_range(0, 7) == 0);
        abort           = ($urandom_range(0, 199) == 0);
        keep_imem       = 1'($urandom_range(0, 1));
        imem_rx_done    = ($urandom_range(0, done_odds - 1) == 0);
        dmem_rx_done    = ($urandom_range(0, done_odds - 1) == 0);
        proc_done       = ($urandom_range(0, done_odds - 1) == 0);
        dmem_tx_done    = ($urandom_range(0, done_odds - 1) == 0);
        uart_imem_wr_en = 1'($urandom_range(0, 1));
        uart_imem_addr  = IA'($urandom());
        uart_imem_data  = IW'($urandom());
        proc_imem_addr  = IA'($urandom());
        uart_dmem_wr_en = 1'($urandom_range(0, 1));
        uart_dmem_addr  = DA'($urandom());
        uart_dmem_data  = DW'({$urandom(), $urandom()});
        proc_dmem_wr_en = 1'($urandom_range(0, 1));
        proc_dmem_addr  = DA'($urandom());
        proc_dmem_data  = DW'({$urandom(), $urandom()});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) check_output();
        end
    end

    initial begin
        int n;
        int base_ps;
        int base_tx;
        int base_ie;

        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        check_val("reset_state", 64'(state), 64'd0);
        check_val("reset_run_count", 64'(run_count), 64'd0);
        check_val("reset_exec_cycles", 64'(exec_cycles), 64'd0);
        check_val("reset_err_code", 64'(err_code), 64'd0);
        check_val("reset_strobes", 64'({imem_rx_en, dmem_rx_en, proc_start, dmem_tx_start, error}), 64'd0);
        rst = 1'b0;

        uart_dmem_addr = 12'h7; proc_dmem_addr = 12'h9;
        uart_dmem_wr_en = 1'b1; proc_dmem_wr_en = 1'b1;
        #1;
        check_val("dmem_addr_idle", 64'(dmem_addr), 64'd0);

        base_ps = cnt_proc_start; base_tx = cnt_tx_start;
        start = 1'b1; next_cycle(); start = 1'b0;
        check_val("run1_load_imem", 64'(state), 64'd1);
        repeat (9) next_cycle();
        imem_rx_done = 1'b1; next_cycle(); imem_rx_done = 1'b0;
        check_val("run1_load_dmem", 64'(state), 64'd2);
        check_val("dmem_addr_load", 64'(dmem_addr), 64'h7);
        repeat (19) next_cycle();
        dmem_rx_done = 1'b1; next_cycle(); dmem_rx_done = 1'b0;
        check_val("run1_execute", 64'(state), 64'd3);
        check_val("run1_proc_start", 64'(proc_start), 64'd1);
        check_val("dmem_addr_exec", 64'(dmem_addr), 64'h9);
        repeat (50) next_cycle();
        proc_done = 1'b1; next_cycle(); proc_done = 1'b0;
        check_val("run1_unload", 64'(state), 64'd4);
        check_val("run1_exec_cycles", 64'(exec_cycles), 64'd50);
        check_val("run1_tx_start", 64'(dmem_tx_start), 64'd1);
        repeat (4) next_cycle();
        dmem_tx_done = 1'b1; next_cycle(); dmem_tx_done = 1'b0;
        check_val("run1_done", 64'(state), 64'd5);
        check_val("run1_run_count", 64'(run_count), 64'd1);
        check_val("dmem_wr_en_done", 64'(dmem_wr_en), 64'd0);
        next_cycle();
        check_val("run1_proc_start_pulses", 64'(cnt_proc_start - base_ps), 64'd1);
        check_val("run1_tx_start_pulses", 64'(cnt_tx_start - base_tx), 64'd1);

        base_ie = cnt_imem_rx_en;
        keep_imem = 1'b1; start = 1'b1; next_cycle(); start = 1'b0;
        check_val("rerun_skip_imem", 64'(state), 64'd2);
        repeat (3) next_cycle();
        dmem_rx_done = 1'b1; next_cycle(); dmem_rx_done = 1'b0;
        repeat (10) next_cycle();
        proc_done = 1'b1; next_cycle(); proc_done = 1'b0;
        check_val("rerun_exec_cycles", 64'(exec_cycles), 64'd10);
        repeat (2) next_cycle();
        dmem_tx_done = 1'b1; next_cycle(); dmem_tx_done = 1'b0;
        check_val("rerun_run_count", 64'(run_count), 64'd2);
        check_val("rerun_imem_rx_en_cycles", 64'(cnt_imem_rx_en - base_ie), 64'd0);

        start = 1'b1; next_cycle(); start = 1'b0;
        dmem_rx_done = 1'b1; next_cycle(); dmem_rx_done = 1'b0;
        n = 0;
        while (state == 3'd3 && n < 300) begin
            n++;
            next_cycle();
        end
        check_val("timeout_exec_len", 64'(n), 64'd100);
        check_val("timeout_state", 64'(state), 64'd6);
        check_val("timeout_err_code", 64'(err_code), 64'd2);
        check_val("timeout_exec_cycles", 64'(exec_cycles), 64'd99);
        start = 1'b1; next_cycle(); start = 1'b0;
        check_val("error_to_idle", 64'(state), 64'd0);
        check_val("error_cleared", 64'(err_code), 64'd0);
        start = 1'b1; next_cycle(); start = 1'b0;
        check_val("keep_after_error_loads_imem", 64'(state), 64'd1);

        imem_rx_done = 1'b1; next_cycle(); imem_rx_done = 1'b0;
        base_ps = cnt_proc_start;
        abort = 1'b1; dmem_rx_done = 1'b1; next_cycle(); abort = 1'b0; dmem_rx_done = 1'b0;
        check_val("abort_state", 64'(state), 64'd6);
        check_val("abort_err_code", 64'(err_code), 64'd3);
        repeat (2) next_cycle();
        check_val("abort_no_proc_start", 64'(cnt_proc_start - base_ps), 64'd0);
        start = 1'b1; next_cycle(); start = 1'b0;

        start = 1'b1; next_cycle(); start = 1'b0;
        imem_rx_done = 1'b1; next_cycle(); imem_rx_done = 1'b0;
        dmem_rx_done = 1'b1; next_cycle(); dmem_rx_done = 1'b0;
        repeat (5) next_cycle();
        rst = 1'b1; next_cycle(); rst = 1'b0;
        check_val("midrun_rst_state", 64'(state), 64'd0);
        check_val("midrun_rst_run_count", 64'(run_count), 64'd0);
        check_val("midrun_rst_exec_cycles", 64'(exec_cycles), 64'd0);
        check_val("midrun_rst_dmem_addr", 64'(dmem_addr), 64'd0);

        for (int i = 0; i < 4000; i++) begin
            case (i / 1000)
                0: done_odds = 12;
                1: done_odds = 150;
                2: done_odds = 4;
                default: done_odds = 40;
            endcase
            apply_stimulus();
            next_cycle();
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        next_cycle();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        n_errors++;
        $display("[TB] FAIL global_time_limit: got expired, expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "[TB] time limit");
    end

endmodule
